// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: sequences a PS/2 receiver FIFO. It pops scan-code bytes and
// folds the Set-2 E0 (extended) and F0 (break) prefixes into single key
// events. It also tracks the held key, flags typematic repeats and counts
// presses. Events go out over a valid/ready handshake, and backpressure stops
// the FIFO from being drained.
// Optional build macro: KBD_ASCII_EN adds a registered Set-2 to ASCII lookup
// on evt_ascii. When the macro is not defined, evt_ascii is tied to 00.
module ps2_kbd_ctrl #(
    parameter int PREFIX_TIMEOUT = 2000000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_release,
    output logic             evt_repeat,
    output logic [7:0]       evt_ascii,
    output logic             held_valid,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky,
    input  logic             err_clr
);

    // The counter only has to reach PREFIX_TIMEOUT-1 before it wraps back.
    localparam int          TW       = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam bit          TMO_ON   = (PREFIX_TIMEOUT != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, POP, SETTLE, EMIT} state_t;

    state_t        state, state_nxt;
    logic [7:0]    byte_q;
    logic          ext_p, brk_p;
    logic [TW-1:0] tmo_cnt;
    logic          is_e0, is_f0, is_drop, is_key;
    logic          key_rep;

    // Classify the latched byte. SETTLE consumes these flags.
    always_comb begin
        is_e0   = (byte_q == 8'hE0);
        is_f0   = (byte_q == 8'hF0);
        is_drop = 1'b0;
        case (byte_q)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: is_drop = 1'b1;
            default:                                          is_drop = 1'b0;
        endcase
        is_key  = !(is_e0 || is_f0 || is_drop);
        key_rep = !brk_p && held_valid && (held_code == {ext_p, byte_q});
    end

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: IDLE -> POP -> SETTLE -> (IDLE | EMIT -> IDLE)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (kbd_ready) state_nxt = POP;
            POP:     state_nxt = SETTLE;
            SETTLE:  state_nxt = is_key ? EMIT : IDLE;
            EMIT:    if (evt_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: pop strobe, prefix folding, prefix timeout, event and held-key registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            kbd_nextdata_n <= 1'b1;
            byte_q         <= 8'h00;
            ext_p          <= 1'b0;
            brk_p          <= 1'b0;
            tmo_cnt        <= '0;
            evt_valid      <= 1'b0;
            evt_code       <= 8'h00;
            evt_ext        <= 1'b0;
            evt_release    <= 1'b0;
            evt_repeat     <= 1'b0;
            held_valid     <= 1'b0;
            held_code      <= 9'h000;
            press_cnt      <= '0;
        end else begin
            // The strobe is low only for the single cycle spent in POP.
            kbd_nextdata_n <= (state_nxt != POP);
            case (state)
                IDLE: begin
                    if (kbd_ready) begin
                        byte_q  <= kbd_data;
                        tmo_cnt <= '0;
                    end else if (TMO_ON && (ext_p || brk_p)) begin
                        if (tmo_cnt == TMO_LAST) begin
                            ext_p   <= 1'b0;
                            brk_p   <= 1'b0;
                            tmo_cnt <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (is_e0) begin
                        ext_p   <= 1'b1;
                        tmo_cnt <= '0;
                    end else if (is_f0) begin
                        brk_p   <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        // Both discarded bytes and real keys use up any pending prefixes.
                        ext_p <= 1'b0;
                        brk_p <= 1'b0;
                        if (is_key) begin
                            evt_code    <= byte_q;
                            evt_ext     <= ext_p;
                            evt_release <= brk_p;
                            evt_repeat  <= key_rep;
                            evt_valid   <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        if (!evt_release) begin
                            if (!evt_repeat) begin
                                held_valid <= 1'b1;
                                held_code  <= {evt_ext, evt_code};
                                press_cnt  <= press_cnt + 1'b1;
                            end
                        end else if (held_code == {evt_ext, evt_code}) begin
                            held_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a clear in the same cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)             ovf_sticky <= 1'b0;
        else if (kbd_overflow) ovf_sticky <= 1'b1;
        else if (err_clr)      ovf_sticky <= 1'b0;
    end

`ifdef KBD_ASCII_EN
    function automatic logic [7:0] set2_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
            8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
            8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
            8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
            8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;  8'h5A: return 8'h0D;
            default: return 8'h00;
        endcase
    endfunction

    // ASCII is loaded together with evt_code. Extended keys have no mapping.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                                evt_ascii <= 8'h00;
        else if (state == SETTLE && is_key)       evt_ascii <= ext_p ? 8'h00 : set2_ascii(byte_q);
    end
`else
    assign evt_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: a behavioural receiver FIFO plus a scoreboard of expected
// key events. Each expected event is pushed when its bytes are queued, and is
// compared when the DUT presents that event for acceptance.
module tb_ps2_kbd_ctrl;

    localparam int CNT_W = 8;

    logic             clk, clrn;
    logic [7:0]       kbd_data;
    logic             kbd_ready, kbd_overflow, kbd_nextdata_n;
    logic             evt_valid, evt_ready, evt_ext, evt_release, evt_repeat;
    logic [7:0]       evt_code, evt_ascii;
    logic             held_valid;
    logic [8:0]       held_code;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_sticky, err_clr;

    ps2_kbd_ctrl #(.PREFIX_TIMEOUT(10), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_release(evt_release), .evt_repeat(evt_repeat),
        .evt_ascii(evt_ascii), .held_valid(held_valid), .held_code(held_code),
        .press_cnt(press_cnt), .ovf_sticky(ovf_sticky), .err_clr(err_clr)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext, rel, rep;
        logic [7:0] asc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rx_q[$];
    int         pops[$];
    int         accs[$];
    int         n_chk = 0, n_fail = 0, n_evt = 0, cyc = 0;

    // Reference key state
    logic       m_hv = 1'b0;
    logic [8:0] m_hc = 9'h000;
    logic [7:0] m_cnt = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_ascii(input logic ext, input logic [7:0] c);
`ifdef KBD_ASCII_EN
        if (ext) return 8'h00;
        case (c)
            8'h1C: return 8'h61; 8'h1B: return 8'h73; 8'h16: return 8'h31;
            8'h75: return 8'h00; 8'h24: return 8'h65;
            default: return 8'h00;
        endcase
`else
        return 8'h00;
`endif
    endfunction

    // Receiver FIFO model: a low strobe pops the head byte; ready/data follow the queue
    always @(negedge clk) begin
        if (!kbd_nextdata_n) begin
            pops.push_back(cyc);
            if (rx_q.size() != 0) void'(rx_q.pop_front());
        end
        kbd_ready = (rx_q.size() != 0);
        kbd_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // Event monitor: compare each event the DUT is about to hand over
    always @(negedge clk) begin
        if (evt_valid && evt_ready) begin
            logic have;
            exp_t e;
            have = (exp_q.size() != 0);
            n_evt++;
            accs.push_back(cyc);
            chk("evt_expected", 32'(have), 32'd1);
            if (have) begin
                e = exp_q.pop_front();
                chk("evt_code", 32'(evt_code), 32'(e.code));
                chk("evt_ext", 32'(evt_ext), 32'(e.ext));
                chk("evt_release", 32'(evt_release), 32'(e.rel));
                chk("evt_repeat", 32'(evt_repeat), 32'(e.rep));
                chk("evt_ascii", 32'(evt_ascii), 32'(e.asc));
            end
        end
    end

    task automatic push_raw(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    // Queue one key's bytes and predict its event and held-key effect
    task automatic send_key(input logic ext, input logic brk, input logic [7:0] c);
        exp_t e;
        if (ext) push_raw(8'hE0);
        if (brk) push_raw(8'hF0);
        push_raw(c);
        e.code = c; e.ext = ext; e.rel = brk;
        e.rep  = !brk && m_hv && (m_hc == {ext, c});
        e.asc  = exp_ascii(ext, c);
        exp_q.push_back(e);
        if (!brk) begin
            if (!e.rep) begin m_hv = 1'b1; m_hc = {ext, c}; m_cnt = m_cnt + 8'd1; end
        end else if (m_hc == {ext, c}) begin
            m_hv = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (rx_q.size() == 0) && !evt_valid && kbd_nextdata_n;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = evt_valid;
        end
        chk({tag, "_valid_wait"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_cnt"}, 32'(press_cnt), 32'(m_cnt));
        chk({tag, "_held_v"}, 32'(held_valid), 32'(m_hv));
        if (m_hv) chk({tag, "_held_c"}, 32'(held_code), 32'(m_hc));
    endtask

    initial begin
        logic [7:0] s_code;
        logic       s_ext, s_rel, s_rep, stable;
        int         n0;

        clrn = 1'b0; evt_ready = 1'b0; kbd_overflow = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_fields", 32'({evt_code, evt_ext, evt_release, evt_repeat, evt_ascii}), 32'd0);
        chk("rst_held", 32'({held_valid, held_code}), 32'd0);
        chk("rst_cnt", 32'(press_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        clrn = 1'b1;

        // Single make 1C: strobe latency and event latency
        @(posedge clk); #1;
        send_key(1'b0, 1'b0, 8'h1C);
        @(negedge clk);
        @(negedge clk); chk("t1_pop_low", 32'(kbd_nextdata_n), 32'd0);
        @(negedge clk); chk("t1_pop_one_cycle", 32'(kbd_nextdata_n), 32'd1);
                        chk("t1_valid_not_early", 32'(evt_valid), 32'd0);
        @(negedge clk); chk("t1_valid_k3", 32'(evt_valid), 32'd1);
        @(posedge clk); #1 evt_ready = 1'b1;
        wait_idle("t1");
        chk_held("t1");

        // Break of the held key
        send_key(1'b0, 1'b1, 8'h1C);
        wait_idle("t2");
        chk_held("t2");

        // Extended and plain 75 are different keys; a repeated E0 75 is typematic
        send_key(1'b1, 1'b0, 8'h75);
        send_key(1'b0, 1'b0, 8'h75);
        wait_idle("t3a");
        chk_held("t3a");
        send_key(1'b1, 1'b0, 8'h75);
        send_key(1'b1, 1'b0, 8'h75);
        wait_idle("t3b");
        chk_held("t3b");

        // Backpressure: events hold steady, no pops; then the queue drains
        @(posedge clk); #1 evt_ready = 1'b0;
        send_key(1'b0, 1'b0, 8'h1B);
        send_key(1'b1, 1'b0, 8'h24);
        wait_valid("t4");
        s_code = evt_code; s_ext = evt_ext; s_rel = evt_release; s_rep = evt_repeat;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!evt_valid || !kbd_nextdata_n || evt_code != s_code || evt_ext != s_ext ||
                evt_release != s_rel || evt_repeat != s_rep) stable = 1'b0;
        end
        chk("t4_stall_stable", 32'(stable), 32'd1);
        chk("t4_stall_code", 32'(s_code), 32'h1B);
        @(posedge clk); #1;
        pops.delete(); accs.delete();
        evt_ready = 1'b1;
        wait_idle("t4");
        chk("t4_pop_count", 32'(pops.size()), 32'd2);
        if (pops.size() >= 2 && accs.size() >= 1) begin
            chk("t4_pop_after_exit", 32'(pops[0] - accs[0]), 32'd2);
            chk("t4_pop_spacing", 32'(pops[1] - pops[0]), 32'd3);
        end else begin
            chk("t4_pop_record", 32'(pops.size()), 32'd2);
        end
        chk_held("t4");

        // Stale break prefix times out, so the next 1C is a make
        push_raw(8'hF0);
        repeat (16) @(posedge clk);
        #1 send_key(1'b0, 1'b0, 8'h1C);
        wait_idle("t5");
        chk_held("t5");

        // Acks and BAT bytes make no event; a discarded byte also clears a pending E0
        n0 = n_evt;
        push_raw(8'hFA);
        push_raw(8'hAA);
        wait_idle("t5d");
        chk("t5_discard_no_evt", 32'(n_evt), 32'(n0));
        push_raw(8'hE0);
        push_raw(8'hFE);
        send_key(1'b0, 1'b0, 8'h1C);
        wait_idle("t5e");
        chk_held("t5e");

        // Sticky overflow flag: set beats clear
        @(posedge clk); #1 kbd_overflow = 1'b1;
        @(posedge clk); #1 kbd_overflow = 1'b0;
        @(negedge clk); chk("t6_ovf_set", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1 kbd_overflow = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1 kbd_overflow = 1'b0; err_clr = 1'b0;
        @(negedge clk); chk("t6_ovf_set_wins", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk); chk("t6_ovf_clr", 32'(ovf_sticky), 32'd0);

        // Asynchronous reset while an event is pending
        @(posedge clk); #1 kbd_overflow = 1'b1; evt_ready = 1'b0;
        push_raw(8'h16);
        @(posedge clk); #1 kbd_overflow = 1'b0;
        wait_valid("t7");
        #2 clrn = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(evt_valid), 32'd0);
        chk("t7_rst_fields", 32'({evt_code, evt_ext, evt_release, evt_repeat, evt_ascii}), 32'd0);
        chk("t7_rst_held", 32'({held_valid, held_code}), 32'd0);
        chk("t7_rst_cnt", 32'(press_cnt), 32'd0);
        chk("t7_rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("t7_rst_nextdata", 32'(kbd_nextdata_n), 32'd1);
        @(negedge clk); clrn = 1'b1;
        m_hv = 1'b0; m_hc = 9'h000; m_cnt = 8'h00;
        @(posedge clk); #1 evt_ready = 1'b1;
        send_key(1'b0, 1'b0, 8'h16);
        wait_idle("t7");
        chk_held("t7");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
